// File: rtl/sumador_secuencial.sv
// sumador_secuencial -- digit-serial adder/subtractor.
//
// Adds (or subtracts) two WIDTH-bit operands DIGIT bits per clock, LSB slice
// first, then publishes the result with a one-cycle done pulse.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request an operation (accepted in IDLE or FIN)
//   sub    in   0 = add, 1 = subtract (sampled with start)
//   a, b   in   WIDTH-bit operands (sampled with start)
//   c_in   in   carry-in (add) / borrow-in (subtract)
//   sum    out  registered result
//   c_out  out  carry out of MSB; in subtract mode 1 = no borrow
//   ovf    out  two's-complement overflow
//   busy   out  high while slices are being processed
//   done   out  one-cycle pulse when sum/c_out/ovf update
//
// WIDTH must be an integer multiple of DIGIT.
module sumador_secuencial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already conditioned by the mode
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] sl_a;
    logic [DIGIT-1:0] sl_b;
    logic [DIGIT:0]   sl_sum;
    logic             last_dig;
    logic             ovf_d;

    // Current slice datapath. Subtraction is a + ~b + ~borrow_in, so the
    // mode is fully captured by the stored b and the initial carry.
    always_comb begin
        sl_a     = a_q[cnt_q*DIGIT +: DIGIT];
        sl_b     = b_q[cnt_q*DIGIT +: DIGIT];
        sl_sum   = {1'b0, sl_a} + {1'b0, sl_b} + {{DIGIT{1'b0}}, carry_q};
        acc_d    = acc_q;
        acc_d[cnt_q*DIGIT +: DIGIT] = sl_sum[DIGIT-1:0];
        last_dig = (cnt_q == CW'(NDIG - 1));
        // Carry-in(MSB) ^ carry-out(MSB) is equivalent to: operand MSBs agree
        // and the result MSB differs from them. This form needs no split of
        // the slice adder and works for DIGIT = 1 too.
        ovf_d    = (sl_a[DIGIT-1] == sl_b[DIGIT-1]) &&
                   (sl_sum[DIGIT-1] != sl_a[DIGIT-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q == RUN) begin
                // start is ignored here: operands and timing are untouched.
                acc_q   <= acc_d;
                carry_q <= sl_sum[DIGIT];
                if (last_dig) begin
                    state_q <= FIN;
                    busy    <= 1'b0;
                    sum     <= acc_d;
                    c_out   <= sl_sum[DIGIT];
                    ovf     <= ovf_d;
                    done    <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (start) begin
                // IDLE or FIN: accept a new operation (back-to-back from FIN).
                state_q <= RUN;
                a_q     <= a;
                b_q     <= b ^ {WIDTH{sub}};
                carry_q <= c_in ^ sub;
                cnt_q   <= '0;
                acc_q   <= '0;
                busy    <= 1'b1;
            end else begin
                state_q <= IDLE;
            end
        end
    end

endmodule
